// File: rtl/forth_pkg.sv
// Shared definitions for the Forth core boot path: instruction width,
// the default frame sync marker and the loader state encoding.
package forth_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/forth_loader.sv
// Boot loader for the Forth core. Parses a framed byte stream
// (sync, LEN_HI, LEN_LO, LEN words high byte first, CHK), writes the words
// into instruction RAM from address 0 and holds the core in reset until a
// frame has loaded and its modulo-256 checksum closes to zero.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rx_data, rx_valid     byte stream from the UART receiver
//   rx_ready              byte accepted when rx_valid & rx_ready
//   imem_waddr/wdata/we   instruction RAM write port (single-cycle strobe)
//   cpu_reset             core reset, high while loading or after a rejected frame
//   done, error           status of the last frame
module forth_loader
  import forth_pkg::*;
#(
  parameter int unsigned iaddr_width    = 10,
  parameter int unsigned timeout_cycles = 1000000,
  parameter logic [7:0]  sync_byte      = SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [iaddr_width-1:0] imem_waddr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned MAX_LEN = 32'd1 << iaddr_width;
  localparam int unsigned TMO_W   = $clog2(timeout_cycles + 1);

  loader_state_e          state_q, state_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [7:0]             hi_q, hi_d;
  logic [iaddr_width-1:0] addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [7:0]             sum_q, sum_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [iaddr_width-1:0] waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_d;
  logic                   we_d, cpu_reset_d, done_d, error_d;
  logic                   accept, active;
  logic [15:0]            len_w;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    waddr_d     = imem_waddr;
    wdata_d     = imem_wdata;
    we_d        = 1'b0;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;

    accept = rx_valid & rx_ready;
    active = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
    len_w  = {len_hi_q, rx_data};

    // Inter-byte idle counter, only running inside a frame
    if (active && !accept) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      SYNC, DONE, ERR: begin
        if (accept && rx_data == sync_byte) begin
          state_d     = LEN_HI;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          sum_d       = '0;
          addr_d      = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          sum_d = sum_q + rx_data;
          cnt_d = len_w;
          // Oversize frames are rejected before any write, so addr never wraps
          if (32'(len_w) > MAX_LEN) begin
            state_d = ERR;
          end else if (len_w == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          sum_d   = sum_q + rx_data;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, rx_data};
          addr_d  = addr_q + iaddr_width'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? CHK : DATA_HI;
        end
      end
      CHK: begin
        if (accept) begin
          state_d = (8'(sum_q + rx_data) == 8'd0) ? DONE : ERR;
        end
      end
      default: state_d = SYNC;
    endcase

    if (active && !accept && tmo_q == TMO_W'(timeout_cycles - 1)) begin
      state_d = ERR;
    end

    // Status outputs follow entry into the terminal states
    if (state_d == DONE && state_q != DONE) begin
      cpu_reset_d = 1'b0;
      done_d      = 1'b1;
      error_d     = 1'b0;
    end
    if (state_d == ERR && state_q != ERR) begin
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b1;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      len_hi_q   <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      rx_ready   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      imem_we    <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      rx_ready   <= 1'b1;
      imem_waddr <= waddr_d;
      imem_wdata <= wdata_d;
      imem_we    <= we_d;
      cpu_reset  <= cpu_reset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_forth_loader.sv
// Self-checking bench for forth_loader. Frames are generated as byte queues;
// a frame-level model derives the expected writes and final status from the
// byte positions, and a compare process checks every cycle.
module tb_forth_loader;

  localparam int unsigned IAW       = 10;
  localparam int unsigned TMO       = 20;
  localparam int          MAX_WORDS = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic [IAW-1:0] imem_waddr;
  logic [15:0]    imem_wdata;
  logic           imem_we;
  logic           cpu_reset;
  logic           done;
  logic           error;

  int  total = 0;
  int  bad = 0;
  int  wr_seen = 0;
  bit  chk_en = 1'b0;
  logic exp_rx_ready = 1'b0;
  logic exp_cpu_reset = 1'b1;
  logic exp_done = 1'b0;
  logic exp_error = 1'b0;
  wr_t exp_wr[$];

  forth_loader #(
    .iaddr_width   (IAW),
    .timeout_cycles(TMO),
    .sync_byte     (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .imem_we   (imem_we),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expectations
  always @(negedge clk) begin : cmp
    wr_t e;
    if (chk_en) begin
      chk("rx_ready", rx_ready, exp_rx_ready);
      chk("cpu_reset", cpu_reset, exp_cpu_reset);
      chk("done", done, exp_done);
      chk("error", error, exp_error);
      if (imem_we === 1'b1) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_we", imem_we, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("waddr", imem_waddr, e.addr);
          chk("wdata", imem_wdata, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_rx_ready = 1'b0;
    exp_cpu_reset = 1'b1;
    exp_done = 1'b0;
    exp_error = 1'b0;
    exp_wr.delete();
    chk_en = 1'b1;
    chk("rst_we", imem_we, 32'd0);
    chk("rst_waddr", imem_waddr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", cpu_reset, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_rx_ready = 1'b1;
  endtask

  // Present one byte after `gap` idle cycles; returns just after the accept edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (rx_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 10) begin
        $display("FAIL rx_ready_wait: got %0b want 1", rx_ready);
        $fatal(1, "rx_ready never asserted");
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Bytes outside a frame that are not the sync marker must be ignored
  task automatic send_junk(input int k);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, $urandom_range(0, 4));
    end
  endtask

  function automatic bq_t build(input int len, input logic [7:0] delta);
    bq_t fb;
    logic [7:0] s;
    logic [15:0] w;
    fb.push_back(8'hA5);
    fb.push_back(8'(len >> 8));
    fb.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      fb.push_back(w[15:8]);
      fb.push_back(w[7:0]);
    end
    s = 8'h00;
    for (int i = 1; i < fb.size(); i++) s = s + fb[i];
    fb.push_back(8'(8'h00 - s + delta));
    return fb;
  endfunction

  // Send the first n bytes of fb; the model is keyed on byte position
  task automatic run_frame(input bq_t fb, input int n, input int gap);
    int len;
    logic [7:0] s;
    wr_t w;
    len = (fb.size() >= 3) ? int'({fb[1], fb[2]}) : -1;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], (gap < 0) ? $urandom_range(0, 4) : gap);
      if (i > 0) s = s + fb[i];
      if (i == 0) begin
        exp_cpu_reset = 1'b1;
        exp_done = 1'b0;
        exp_error = 1'b0;
      end else if (len > MAX_WORDS) begin
        if (i == 2) begin
          exp_cpu_reset = 1'b1;
          exp_error = 1'b1;
        end
      end else if (i >= 4 && i < 3 + 2 * len && (i % 2) == 0) begin
        w.addr = (i - 4) / 2;
        w.data = {fb[i-1], fb[i]};
        exp_wr.push_back(w);
      end else if (i == 3 + 2 * len) begin
        if (s == 8'h00) begin
          exp_cpu_reset = 1'b0;
          exp_done = 1'b1;
        end else begin
          exp_cpu_reset = 1'b1;
          exp_error = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fb;
    int w0;
    logic [7:0] delta;

    do_reset();
    send_junk(4);

    // 00+03+E0+40+12+34+80+05 = 0x1EE, so 0x12 closes the sum
    fb = '{8'hA5, 8'h00, 8'h03, 8'hE0, 8'h40, 8'h12, 8'h34, 8'h80, 8'h05, 8'h12};
    w0 = wr_seen;
    run_frame(fb, fb.size(), -1);
    chk("good_done", done, 32'd1);
    chk("good_cpu_reset", cpu_reset, 32'd0);
    chk("good_writes", wr_seen - w0, 32'd3);
    chk("good_last_waddr", imem_waddr, 32'd2);
    chk("good_last_wdata", imem_wdata, 32'h8005);
    send_junk(3);

    // Same words, checksums that do not close
    fb[9] = 8'h13;
    w0 = wr_seen;
    run_frame(fb, fb.size(), -1);
    chk("badchk_error", error, 32'd1);
    chk("badchk_done", done, 32'd0);
    chk("badchk_writes", wr_seen - w0, 32'd3);
    fb[9] = 8'h62;
    run_frame(fb, fb.size(), -1);
    chk("badchk62_error", error, 32'd1);
    send_junk(2);

    // LEN = 1025 is one past the RAM
    fb = '{8'hA5, 8'h04, 8'h01};
    w0 = wr_seen;
    run_frame(fb, fb.size(), -1);
    repeat (2) @(posedge clk);
    chk("oversize_error", error, 32'd1);
    chk("oversize_writes", wr_seen - w0, 32'd0);

    fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
    w0 = wr_seen;
    run_frame(fb, fb.size(), -1);
    chk("len0_done", done, 32'd1);
    chk("len0_writes", wr_seen - w0, 32'd0);

    // LEN = 1024 fills RAM exactly
    fb = build(MAX_WORDS, 8'h00);
    w0 = wr_seen;
    run_frame(fb, fb.size(), 0);
    chk("full_done", done, 32'd1);
    chk("full_writes", wr_seen - w0, 32'd1024);
    chk("full_last_waddr", imem_waddr, 32'd1023);

    // Idle for the full timeout mid-frame
    fb = '{8'hA5, 8'h00, 8'h02, 8'hE0};
    run_frame(fb, fb.size(), -1);
    repeat (TMO) @(posedge clk);
    #1;
    exp_cpu_reset = 1'b1;
    exp_error = 1'b1;
    @(negedge clk);
    chk("timeout_error", error, 32'd1);
    send_junk(3);

    // One cycle short of the timeout between every byte
    fb = build(1, 8'h00);
    run_frame(fb, fb.size(), TMO - 1);
    chk("slow_done", done, 32'd1);

    // Reset after the second data byte
    fb = build(3, 8'h00);
    w0 = wr_seen;
    run_frame(fb, 5, -1);
    do_reset();
    repeat (3) @(posedge clk);
    chk("midrst_writes", wr_seen - w0, 32'd1);
    chk("midrst_cpu_reset", cpu_reset, 32'd1);
    chk("midrst_done", done, 32'd0);
    fb = build(3, 8'h00);
    run_frame(fb, fb.size(), -1);
    chk("after_rst_done", done, 32'd1);

    // Random frames, reloading after DONE and after ERR
    for (int k = 0; k < 40; k++) begin
      delta = ($urandom_range(0, 9) < 7) ? 8'h00 : 8'($urandom_range(1, 255));
      fb = build($urandom_range(0, 8), delta);
      run_frame(fb, fb.size(), -1);
      send_junk($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk("writes_drained", exp_wr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
